// File: rtl/plat_collision_scanner_if.sv
// Bus between the platform generator / jump logic and plat_collision_scanner.
// Carries the platform table, the Doodle geometry and the published scan results.
interface plat_collision_scanner_if #(
  parameter int NUM_PLAT = 16,
  parameter int XW       = 10,
  parameter int YW       = 10
);
  localparam int IDX_W = $clog2(NUM_PLAT);

  logic [NUM_PLAT*XW-1:0] plat_x;
  logic [NUM_PLAT*YW-1:0] plat_y;
  logic [NUM_PLAT-1:0]    plat_valid;
  logic [XW-1:0]          plat_size_x;
  logic [YW-1:0]          plat_size_y;
  logic [XW-1:0]          doodle_x;
  logic [YW-1:0]          doodle_y;
  logic [XW-1:0]          doodle_s;
  logic [YW-1:0]          doodle_y_motion;

  logic                   collision;
  logic [IDX_W-1:0]       collision_idx;
  logic [YW-1:0]          collision_y;
  logic [NUM_PLAT-1:0]    collision_vec;
  logic                   busy;
  logic                   scan_done;

  modport master (
    output plat_x, plat_y, plat_valid, plat_size_x, plat_size_y,
    output doodle_x, doodle_y, doodle_s, doodle_y_motion,
    input  collision, collision_idx, collision_y, collision_vec, busy, scan_done
  );

  modport slave (
    input  plat_x, plat_y, plat_valid, plat_size_x, plat_size_y,
    input  doodle_x, doodle_y, doodle_s, doodle_y_motion,
    output collision, collision_idx, collision_y, collision_vec, busy, scan_done
  );
endinterface

// File: rtl/plat_collision_scanner.sv
// Frame-triggered platform collision scanner: one platform slot per clock.
// Optional macro PLAT_SCAN_NEAREST_EN picks the nearest hit instead of the lowest index.
module plat_collision_scanner #(
  parameter int NUM_PLAT = 16,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  plat_collision_scanner_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_PLAT);
  localparam int XE    = XW + 2;
  localparam int YE    = YW + 2;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  logic             fs_meta, fs_sync, fs_prev;
  logic             start;

  logic [XW-1:0]    snap_x;
  logic [YW-1:0]    snap_y;
  logic [XW-1:0]    snap_s;
  logic [YW-1:0]    snap_m;

  logic [IDX_W-1:0] index;
  logic [NUM_PLAT-1:0] hit_vec;
  logic             found;
  logic [IDX_W-1:0] win_idx;
  logic [YW-1:0]    win_y;
`ifdef PLAT_SCAN_NEAREST_EN
  logic [YW-1:0]    best_dist;
  logic [YW-1:0]    dist;
`endif

  logic [XW-1:0]    slot_x [NUM_PLAT];
  logic [YW-1:0]    slot_y [NUM_PLAT];
  logic [XW-1:0]    cur_x;
  logic [YW-1:0]    cur_y;
  logic [YE-1:0]    foot, py_lo, py_hi;
  logic [XE-1:0]    x_right, x_left, px_lo, px_hi;
  logic             falling, hit, take, last;
  logic [NUM_PLAT-1:0] vec_next;
  logic             found_next;
  logic [IDX_W-1:0] idx_next;
  logic [YW-1:0]    y_next;

  for (genvar g = 0; g < NUM_PLAT; g++) begin : g_slot
    assign slot_x[g] = bus.plat_x[g*XW +: XW];
    assign slot_y[g] = bus.plat_y[g*YW +: YW];
  end

  // frame_clk is asynchronous: two flops, then an edge register for the rise
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs_meta <= 1'b0;
      fs_sync <= 1'b0;
      fs_prev <= 1'b0;
    end else begin
      fs_meta <= frame_clk;
      fs_sync <= fs_meta;
      fs_prev <= fs_sync;
    end
  end

  assign start = fs_sync & ~fs_prev;

  // Widened compares with additions only, so no term can wrap around
  always_comb begin
    cur_x   = slot_x[index];
    cur_y   = slot_y[index];
    foot    = YE'(snap_y) + YE'(snap_s);
    py_lo   = YE'(cur_y);
    py_hi   = YE'(cur_y) + YE'(bus.plat_size_y);
    x_left  = XE'(snap_x);
    x_right = XE'(snap_x) + XE'(snap_s);
    px_lo   = XE'(cur_x);
    px_hi   = XE'(cur_x) + XE'(bus.plat_size_x) + XE'(snap_s);
    falling = ~snap_m[YW-1] & (|snap_m);
    hit     = bus.plat_valid[index] & falling &
              (py_lo <= foot) & (foot < py_hi) &
              (x_right >= px_lo) & (x_left < px_hi);
    vec_next = hit_vec | (hit ? (NUM_PLAT'(1) << index) : '0);
`ifdef PLAT_SCAN_NEAREST_EN
    dist = YW'(foot - py_lo);
    take = hit & (~found | (dist < best_dist));
`else
    take = hit & ~found;
`endif
    found_next = found | hit;
    idx_next   = take ? index : win_idx;
    y_next     = take ? cur_y : win_y;
    last       = (index == IDX_W'(NUM_PLAT - 1));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state             <= IDLE;
      snap_x            <= '0;
      snap_y            <= '0;
      snap_s            <= '0;
      snap_m            <= '0;
      index             <= '0;
      hit_vec           <= '0;
      found             <= 1'b0;
      win_idx           <= '0;
      win_y             <= '0;
`ifdef PLAT_SCAN_NEAREST_EN
      best_dist         <= '0;
`endif
      bus.collision     <= 1'b0;
      bus.collision_idx <= '0;
      bus.collision_y   <= '0;
      bus.collision_vec <= '0;
      bus.busy          <= 1'b0;
      bus.scan_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.scan_done <= 1'b0;
          if (start) begin
            state    <= SCAN;
            bus.busy <= 1'b1;
            snap_x   <= bus.doodle_x;
            snap_y   <= bus.doodle_y;
            snap_s   <= bus.doodle_s;
            snap_m   <= bus.doodle_y_motion;
            index    <= '0;
            hit_vec  <= '0;
            found    <= 1'b0;
            win_idx  <= '0;
            win_y    <= '0;
`ifdef PLAT_SCAN_NEAREST_EN
            best_dist <= '0;
`endif
          end
        end
        SCAN: begin
          hit_vec <= vec_next;
          found   <= found_next;
          win_idx <= idx_next;
          win_y   <= y_next;
`ifdef PLAT_SCAN_NEAREST_EN
          if (take) best_dist <= dist;
`endif
          if (last) begin
            state             <= DONE;
            bus.collision     <= found_next;
            bus.collision_idx <= idx_next;
            bus.collision_y   <= y_next;
            bus.collision_vec <= vec_next;
            bus.scan_done     <= 1'b1;
          end else begin
            index <= index + IDX_W'(1);
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.scan_done <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.scan_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_plat_collision_scanner.sv
// Self-checking bench for plat_collision_scanner: directed table, corner sequences,
// and randomized frames compared against a rule-level reference model.
module tb_plat_collision_scanner;
  localparam int NUM_PLAT = 16;
  localparam int XW       = 10;
  localparam int YW       = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic frame_clk = 1'b0;

  always #5 clk = ~clk;

  plat_collision_scanner_if #(.NUM_PLAT(NUM_PLAT), .XW(XW), .YW(YW)) bus ();

  plat_collision_scanner #(.NUM_PLAT(NUM_PLAT), .XW(XW), .YW(YW)) dut (
    .Clk(clk),
    .Reset_n(reset_n),
    .frame_clk(frame_clk),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int dx, dy, ds, mot;
    bit v5;
    bit ec;
    int ei, ey;
    logic [15:0] ev;
  } vec_t;

  vec_t tbl[$];

  int obs_done, obs_busy, obs_lat;
  bit obs_hold, obs_busy_at_done;

  int px_a[NUM_PLAT];
  int py_a[NUM_PLAT];
  bit v_a[NUM_PLAT];
  int r_sx, r_sy, r_dx, r_dy, r_ds, r_mot;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int dx, input int dy, input int ds, input int mot, input bit v5,
                         input bit ec, input int ei, input int ey, input logic [15:0] ev);
    vec_t v;
    v.dx = dx; v.dy = dy; v.ds = ds; v.mot = mot; v.v5 = v5;
    v.ec = ec; v.ei = ei; v.ey = ey; v.ev = ev;
    tbl.push_back(v);
  endtask

  task automatic clear_platforms();
    for (int i = 0; i < NUM_PLAT; i++) begin
      bus.plat_x[i*XW +: XW] = 10'd600;
      bus.plat_y[i*YW +: YW] = 10'd600;
      bus.plat_valid[i] = 1'b0;
    end
    bus.plat_size_x = 10'd40;
    bus.plat_size_y = 10'd8;
  endtask

  task automatic set_slot(input int i, input int x, input int y, input bit v);
    bus.plat_x[i*XW +: XW] = XW'(x);
    bus.plat_y[i*YW +: YW] = YW'(y);
    bus.plat_valid[i] = v;
  endtask

  task automatic set_doodle(input int dx, input int dy, input int ds, input int mot);
    bus.doodle_x = XW'(dx);
    bus.doodle_y = YW'(dy);
    bus.doodle_s = XW'(ds);
    bus.doodle_y_motion = YW'(mot);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_coll"}, 64'(bus.collision), 64'd0);
    check_val({tag, "_idx"}, 64'(bus.collision_idx), 64'd0);
    check_val({tag, "_y"}, 64'(bus.collision_y), 64'd0);
    check_val({tag, "_vec"}, 64'(bus.collision_vec), 64'd0);
    check_val({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check_val({tag, "_done"}, 64'(bus.scan_done), 64'd0);
  endtask

  // Raise frame_clk one cycle-phase away from the edge and watch the whole scan
  task automatic apply_stimulus(input bit second_rise);
    logic [38:0] prev;
    prev = {bus.collision, bus.collision_idx, bus.collision_y, bus.collision_vec};
    obs_done = 0; obs_busy = 0; obs_lat = -1; obs_hold = 1'b1; obs_busy_at_done = 1'b0;
    frame_clk = 1'b1;
    for (int c = 1; c <= NUM_PLAT + 12; c++) begin
      @(posedge clk); #1;
      if (c == 4) frame_clk = 1'b0;
      if (second_rise && c == 8) frame_clk = 1'b1;
      if (second_rise && c == 12) frame_clk = 1'b0;
      if (bus.busy) obs_busy++;
      if (bus.scan_done) begin
        obs_done++;
        if (obs_lat < 0) begin
          obs_lat = c;
          obs_busy_at_done = bus.busy;
        end
      end else if (obs_done == 0 &&
                   {bus.collision, bus.collision_idx, bus.collision_y, bus.collision_vec} != prev) begin
        obs_hold = 1'b0;
      end
    end
  endtask

  task automatic check_output(input string tag, input bit ec, input int ei, input int ey,
                              input logic [15:0] ev);
    check_val({tag, "_coll"}, 64'(bus.collision), 64'(ec));
    check_val({tag, "_idx"}, 64'(bus.collision_idx), 64'(ei));
    check_val({tag, "_y"}, 64'(bus.collision_y), 64'(ey));
    check_val({tag, "_vec"}, 64'(bus.collision_vec), 64'(ev));
    check_val({tag, "_done_count"}, 64'(obs_done), 64'd1);
    check_val({tag, "_busy_cycles"}, 64'(obs_busy), 64'(NUM_PLAT + 1));
    check_val({tag, "_latency_ok"}, 64'(obs_lat == NUM_PLAT + 3 || obs_lat == NUM_PLAT + 4), 64'd1);
    check_val({tag, "_busy_at_done"}, 64'(obs_busy_at_done), 64'd1);
    check_val({tag, "_hold"}, 64'(obs_hold), 64'd1);
  endtask

  // Reference: apply the hit rules to every slot with plain integer arithmetic
  task automatic model(output bit ec, output int ei, output int ey, output logic [15:0] ev);
    int foot, m, best, d;
    bit h;
    foot = r_dy + r_ds;
    m = (r_mot >= 512) ? r_mot - 1024 : r_mot;
    ec = 0; ei = 0; ey = 0; ev = '0; best = 0;
    for (int i = 0; i < NUM_PLAT; i++) begin
      h = v_a[i] && (m > 0) && (py_a[i] <= foot) && (foot < py_a[i] + r_sy) &&
          (r_dx + r_ds >= px_a[i]) && (r_dx < px_a[i] + r_sx + r_ds);
      ev[i] = h;
      d = foot - py_a[i];
`ifdef PLAT_SCAN_NEAREST_EN
      if (h && (!ec || d < best)) begin
`else
      if (h && !ec) begin
`endif
        ec = 1; ei = i; ey = py_a[i]; best = d;
      end
    end
  endtask

  initial begin
    bit ec;
    int ei, ey;
    logic [15:0] ev;
    bit wide;

    add_vec(110, 290, 12, 4,       1, 1, 5, 300, 16'h0020);
    add_vec(110, 290, 12, 10'h3FD, 1, 0, 0, 0,   16'h0000);
    add_vec(110, 290, 12, 0,       1, 0, 0, 0,   16'h0000);
    add_vec(88,  290, 12, 4,       1, 1, 5, 300, 16'h0020);
    add_vec(87,  290, 12, 4,       1, 0, 0, 0,   16'h0000);
    add_vec(151, 290, 12, 4,       1, 1, 5, 300, 16'h0020);
    add_vec(152, 290, 12, 4,       1, 0, 0, 0,   16'h0000);
    add_vec(110, 290, 12, 4,       0, 0, 0, 0,   16'h0000);
    add_vec(110, 288, 12, 4,       1, 1, 5, 300, 16'h0020);
    add_vec(110, 287, 12, 4,       1, 0, 0, 0,   16'h0000);
    add_vec(110, 295, 12, 4,       1, 1, 5, 300, 16'h0020);
    add_vec(110, 296, 12, 4,       1, 0, 0, 0,   16'h0000);
    add_vec(110, 290, 12, 10'h1FF, 1, 1, 5, 300, 16'h0020);
    add_vec(110, 290, 12, 10'h200, 1, 0, 0, 0,   16'h0000);

    clear_platforms();
    set_doodle(110, 290, 12, 4);

    repeat (3) @(posedge clk);
    #1;
    check_zero("in_reset");
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_zero("after_reset");

    for (int i = 0; i < tbl.size(); i++) begin
      clear_platforms();
      set_slot(5, 100, 300, tbl[i].v5);
      set_doodle(tbl[i].dx, tbl[i].dy, tbl[i].ds, tbl[i].mot);
      apply_stimulus(1'b0);
      check_output($sformatf("table%0d", i), tbl[i].ec, tbl[i].ei, tbl[i].ey, tbl[i].ev);
    end

    clear_platforms();
    set_slot(2, 100, 296, 1'b1);
    set_slot(9, 100, 301, 1'b1);
    set_doodle(110, 290, 12, 4);
    apply_stimulus(1'b0);
`ifdef PLAT_SCAN_NEAREST_EN
    check_output("multi_hit", 1, 9, 301, 16'h0204);
`else
    check_output("multi_hit", 1, 2, 296, 16'h0204);
`endif

    clear_platforms();
    set_slot(5, 100, 300, 1'b1);
    set_doodle(110, 290, 12, 4);
    apply_stimulus(1'b1);
    check_output("second_rise", 1, 5, 300, 16'h0020);

    frame_clk = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.busy == 1'b0 && frame_clk == 1'b1) frame_clk = 1'b1;
    end
    frame_clk = 1'b0;
    check_val("midscan_busy", 64'(bus.busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_zero("midscan_reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check_zero("post_reset_quiet");
    apply_stimulus(1'b0);
    check_output("post_reset_scan", 1, 5, 300, 16'h0020);

    for (int n = 0; n < 30; n++) begin
      wide = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < NUM_PLAT; i++) begin
        px_a[i] = wide ? $urandom_range(980, 1023) : $urandom_range(60, 180);
        py_a[i] = wide ? $urandom_range(1000, 1023) : $urandom_range(270, 320);
        v_a[i]  = ($urandom_range(0, 3) != 0);
        set_slot(i, px_a[i], py_a[i], v_a[i]);
      end
      r_sx  = wide ? $urandom_range(0, 60) : $urandom_range(20, 60);
      r_sy  = wide ? $urandom_range(0, 30) : $urandom_range(4, 16);
      r_dx  = wide ? $urandom_range(980, 1023) : $urandom_range(40, 260);
      r_dy  = wide ? $urandom_range(1000, 1023) : $urandom_range(260, 315);
      r_ds  = wide ? $urandom_range(0, 30) : $urandom_range(4, 20);
      r_mot = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(1, 8);
      bus.plat_size_x = XW'(r_sx);
      bus.plat_size_y = YW'(r_sy);
      set_doodle(r_dx, r_dy, r_ds, r_mot);
      model(ec, ei, ey, ev);
      apply_stimulus(1'b0);
      check_output($sformatf("rand%0d", n), ec, ei, ey, ev);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
